// File: rtl/backscatter_modulator.sv
// Backscatter RF-switch driver: square-wave FSK carrier with per-bit phase inversion, symbol-locked to the serializer.
// Build option DIFF_ENC_EN: differential phase encoding instead of absolute.
module backscatter_modulator #(
  parameter int SYMBOL_CYCLES = 50,
  parameter int HALF_PERIOD   = 2,
  parameter int FRAME_BITS    = 144,
  parameter int BIT_CNT_W     = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 trigger,
  input  logic                 data_in,
  output logic                 rf_ctrl,
  output logic                 busy,
  output logic                 frame_done,
  output logic [BIT_CNT_W-1:0] bits_sent
);

  localparam logic [15:0]          SYM_LAST = 16'(SYMBOL_CYCLES - 1);
  localparam logic [15:0]          DIV_LAST = 16'(HALF_PERIOD - 1);
  localparam logic [BIT_CNT_W-1:0] ALL_BITS = BIT_CNT_W'(FRAME_BITS);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state;
  logic [15:0] sym_cnt;
  logic [15:0] div_cnt;
  logic        sq;
  logic        phase;
  logic        run;
  logic        next_phase;

`ifdef DIFF_ENC_EN
  assign next_phase = phase ^ data_in;
`else
  assign next_phase = data_in;
`endif

  assign rf_ctrl = run & (sq ^ phase);
  assign busy    = (state == RUN);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      sym_cnt    <= '0;
      div_cnt    <= '0;
      sq         <= 1'b0;
      phase      <= 1'b0;
      run        <= 1'b0;
      bits_sent  <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      // Trigger low outside IDLE is either an abort or the DONE release; both fully clear.
      if (state != IDLE && !trigger) begin
        state     <= IDLE;
        sym_cnt   <= '0;
        div_cnt   <= '0;
        sq        <= 1'b0;
        phase     <= 1'b0;
        run       <= 1'b0;
        bits_sent <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (trigger) begin
              state   <= RUN;
              run     <= 1'b1;
              sym_cnt <= 16'd1;
            end
          end
          RUN: begin
            sym_cnt <= (sym_cnt == SYM_LAST) ? '0 : sym_cnt + 16'd1;
            if (div_cnt == DIV_LAST) begin
              div_cnt <= '0;
              sq      <= ~sq;
            end else begin
              div_cnt <= div_cnt + 16'd1;
            end
            // Latch one cycle after the serializer updates data_in.
            if (sym_cnt == 16'd1 && bits_sent != ALL_BITS) begin
              phase     <= next_phase;
              bits_sent <= bits_sent + 1'b1;
            end
            if (sym_cnt == SYM_LAST && bits_sent == ALL_BITS) begin
              state      <= DONE;
              run        <= 1'b0;
              phase      <= 1'b0;
              sq         <= 1'b0;
              div_cnt    <= '0;
              sym_cnt    <= '0;
              frame_done <= 1'b1;
            end
          end
          DONE: ;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_backscatter_modulator.sv
// Randomized bench for backscatter_modulator against an arithmetic per-cycle model of the frame timeline.
module tb_backscatter_modulator;
  localparam int SC   = 50;
  localparam int HP   = 2;
  localparam int FB   = 144;
  localparam int BW   = 8;
  localparam int LAST = SC * FB - 1;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          trigger = 1'b0;
  logic          data_in = 1'b0;
  logic          rf_ctrl;
  logic          busy;
  logic          frame_done;
  logic [BW-1:0] bits_sent;

  int n_tests = 0;
  int n_fail  = 0;
  bit bits[FB];
  bit ph[FB];

  backscatter_modulator #(
    .SYMBOL_CYCLES(SC), .HALF_PERIOD(HP), .FRAME_BITS(FB), .BIT_CNT_W(BW)
  ) dut (
    .clock(clock), .reset(reset), .trigger(trigger), .data_in(data_in),
    .rf_ctrl(rf_ctrl), .busy(busy), .frame_done(frame_done), .bits_sent(bits_sent)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".rf_ctrl"}, 32'(rf_ctrl), 0);
    chk({tag, ".busy"}, 32'(busy), 0);
    chk({tag, ".frame_done"}, 32'(frame_done), 0);
    chk({tag, ".bits_sent"}, 32'(bits_sent), 0);
  endtask

  // Random frame payload, optionally starting with the known preamble; ph[] is the phase each bit should produce.
  task automatic fill(input bit preamble);
    bit p;
    for (int k = 0; k < FB; k++) bits[k] = 1'($urandom_range(0, 1));
    if (preamble) begin
`ifdef DIFF_ENC_EN
      bits[0] = 1; bits[1] = 1; bits[2] = 0; bits[3] = 1;
`else
      bits[0] = 1; bits[1] = 0; bits[2] = 0; bits[3] = 1;
`endif
    end
    p = 0;
    for (int k = 0; k < FB; k++) begin
`ifdef DIFF_ENC_EN
      p = p ^ bits[k];
`else
      p = bits[k];
`endif
      ph[k] = p;
    end
  endtask

  // n = edges since t0 (t0 itself is n=0); abort_at = edge at which trigger is seen low (0 = never).
  task automatic check_at(input int n, input int abort_at);
    int e_rf, e_busy, e_done, e_bits, k;
    if (abort_at > 0 && n >= abort_at) begin
      e_rf = 0; e_busy = 0; e_done = 0; e_bits = 0;
    end else if (n >= LAST) begin
      e_rf = 0; e_busy = 0; e_done = (n == LAST) ? 1 : 0; e_bits = FB;
    end else begin
      e_busy = 1; e_done = 0;
      if (n == 0) begin
        e_bits = 0; e_rf = 0;
      end else begin
        k = (n - 1) / SC;
        e_bits = k + 1;
        e_rf = ((n / HP) % 2) ^ int'(ph[k]);
      end
    end
    chk("rf_ctrl", 32'(rf_ctrl), 32'(e_rf));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("frame_done", 32'(frame_done), 32'(e_done));
    chk("bits_sent", 32'(bits_sent), 32'(e_bits));
  endtask

  task automatic run_frame(input int abort_at, input int done_hold);
    trigger = 1'b1;
    @(posedge clock); #1;
    data_in = bits[0];
    check_at(0, abort_at);
    if (abort_at == 1) trigger = 1'b0;
    for (int n = 1; n <= LAST + done_hold; n++) begin
      @(posedge clock); #1;
      check_at(n, abort_at);
      if (n % SC == 0 && n / SC < FB) data_in = bits[n / SC];
      if (abort_at > 0 && n + 1 == abort_at) trigger = 1'b0;
      if (abort_at > 0 && n >= abort_at + 2) break;
    end
    if (trigger) begin
      trigger = 1'b0;
      @(posedge clock); #1;
      chk_idle("release");
    end
    data_in = 1'b0;
    @(posedge clock); #1;
    chk_idle("gap");
  endtask

  initial begin
    #2 reset = 1'b0;
    #1 chk_idle("reset");
    @(posedge clock); #1;
    reset = 1'b1;
    repeat (5) begin
      @(posedge clock); #1;
      chk_idle("idle_after_reset");
    end

    fill(1); run_frame(0, 5);
    fill(0); run_frame(3000, 0);
    fill(0); run_frame(LAST, 0);
    fill(0); run_frame(int'($urandom_range(2, LAST - 1)), 0);
    fill(0); run_frame(0, 1);

    // Asynchronous reset in the middle of a frame.
    fill(0);
    trigger = 1'b1;
    @(posedge clock); #1;
    data_in = bits[0];
    repeat (1234) @(posedge clock);
    #3 reset = 1'b0;
    #1 chk_idle("mid_reset");
    trigger = 1'b0;
    data_in = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    repeat (3) begin
      @(posedge clock); #1;
      chk_idle("idle_after_mid_reset");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/backscatter_modulator.md
Name: backscatter_modulator

Overview:
- Downstream consumer of the frame serializer. It takes the serialized bit stream (one bit per SYMBOL_CYCLES trigger cycles, 144-bit frame) and drives the tag RF switch.
- The switch is driven with a square-wave frequency-shift carrier whose phase is inverted per data bit (codeword translation).
- It runs symbol-locked to the serializer from the same trigger, counts bits, and flags frame completion.

Parameters:
- SYMBOL_CYCLES, 50, clock cycles per data bit; must equal the serializer bit period.
- HALF_PERIOD, 2, clock cycles per half-cycle of the shift square wave; must be ≥1.
- FRAME_BITS, 144, bits per frame.
- BIT_CNT_W, 8, width of the bit counter; must satisfy 2^BIT_CNT_W > FRAME_BITS.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- trigger  input  1  frame enable shared with the serializer; high = transmit, low = idle/abort.
- data_in  input  1  serialized bit from the serializer output.
- rf_ctrl  output  1  RF switch drive; equals run & (sq ^ phase), all three registered, so it is glitch-free per edge.
- busy  output  1  high while in RUN.
- frame_done  output  1  one-cycle pulse at end of the last symbol.
- bits_sent  output  BIT_CNT_W  number of bits latched in the current frame.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - sym_cnt=0, div_cnt=0, sq=0, phase=0, run=0.
  - bits_sent=0, frame_done=0, rf_ctrl=0, busy=0.
- States are IDLE, RUN and DONE. frame_done defaults to 0 on every edge unless set below.
- IDLE:
  - All counters and flags are held at their reset values.
  - On an edge with trigger=1: go to RUN, run=1, sym_cnt=1. That edge is t0.
  - At t0 the serializer updates data_in, so data_in is valid from t0 onward.
- RUN, symbol counter:
  - sym_cnt counts 0..SYMBOL_CYCLES-1 and wraps to 0, in lockstep with the serializer.
  - On an edge with sym_cnt==1: phase<=data_in and bits_sent<=bits_sent+1.
  - So the phase for bit k takes effect after edge t0+1+k*SYMBOL_CYCLES. This is a one-cycle latency from the serializer update.
- RUN, carrier:
  - div_cnt increments each edge. When div_cnt==HALF_PERIOD-1, div_cnt wraps to 0 and sq toggles.
  - The carrier period is 2*HALF_PERIOD cycles.
  - sq starts at 0 at t0 and is free-running for the whole frame; it is not realigned per symbol.
- RUN, frame end:
  - End condition: an edge with sym_cnt==SYMBOL_CYCLES-1 and bits_sent==FRAME_BITS. With defaults this is edge t0+7199.
  - At that edge: go to DONE, run=0, phase=0, sq=0, div_cnt=0, frame_done=1 for exactly one cycle.
  - bits_sent holds FRAME_BITS.
- DONE:
  - rf_ctrl=0 and busy=0; bits_sent is held.
  - When trigger=0, go to IDLE and clear all registers.
  - No retransmission occurs until trigger drops and rises again.
- Abort: trigger=0 in RUN at any edge, including the final symbol edge.
  - Go to IDLE and clear all registers, as in reset.
  - frame_done is not pulsed; abort has priority over the end condition.
- Width rules:
  - sym_cnt is 16 bits and compares against SYMBOL_CYCLES-1.
  - bits_sent never exceeds FRAME_BITS, so there is no wrap.
- Asynchronous reset mid-frame returns immediately to the reset values.

Optional Feature:
- Macro: DIFF_ENC_EN.
- Defined: differential encoding. At each latch, phase<=phase ^ data_in, so a 1 flips the phase relative to the previous symbol and a 0 holds it. Phase is 0 at frame start.
- Undefined: absolute encoding, phase<=data_in.
- All timing is identical in both builds.

Test Plan:
- Reset: assert reset=0 mid-RUN → all outputs 0 immediately; after release with trigger=0, the block stays in IDLE with rf_ctrl=0.
- Carrier, HALF_PERIOD=2: trigger high with data_in=0 → from t0+1, rf_ctrl follows the pattern 0,1,1,0,0,1,1,… with period 4 cycles.
- Phase: feed preamble bits 1,0,0,1 (absolute build) → rf_ctrl is inverted vs sq during symbols 0 and 3; bits_sent reads 1 after t0+1 and 4 after t0+151.
- Full frame, defaults: trigger held high → frame_done high for exactly one cycle after edge t0+7199; bits_sent=144; rf_ctrl=0 in DONE. Drop trigger → IDLE with bits_sent=0.
- Abort: drop trigger at t0+3000 → rf_ctrl, busy and bits_sent return to 0 next cycle; no frame_done pulse.
- DIFF_ENC_EN build: bits 1,1,0,1 → phase sequence 1,0,0,1; rf_ctrl equals sq^phase in each symbol.
